// File: rtl/nbody_step_sequencer_if.sv
// Sequencer bus: software run/ack control, pair issue to the acceleration pipe,
// tagged acceleration return and position-sweep addressing.
interface nbody_step_sequencer_if #(
  parameter int BODIES    = 512,
  parameter int GAP_WIDTH = 16
);
  localparam int BODY_ADDR_WIDTH = $clog2(BODIES);

  logic                       go;
  logic                       ack;
  logic [BODY_ADDR_WIDTH:0]   num_bodies;
  logic [GAP_WIDTH-1:0]       gap;
  logic                       busy;
  logic                       done;
  logic                       first_step;
  logic                       pair_valid;
  logic [BODY_ADDR_WIDTH-1:0] pair_i;
  logic [BODY_ADDR_WIDTH-1:0] pair_j;
  logic                       acc_valid;
  logic [BODY_ADDR_WIDTH-1:0] acc_i;
  logic [BODY_ADDR_WIDTH-1:0] acc_j;
  logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr;
  logic                       pos_wr_en;
  logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr;

  modport master (
    output go, ack, num_bodies, gap,
    input  busy, done, first_step, pair_valid, pair_i, pair_j,
           acc_valid, acc_i, acc_j, pos_rd_addr, pos_wr_en, pos_wr_addr
  );

  modport slave (
    input  go, ack, num_bodies, gap,
    output busy, done, first_step, pair_valid, pair_i, pair_j,
           acc_valid, acc_i, acc_j, pos_rd_addr, pos_wr_en, pos_wr_addr
  );
endinterface

// File: rtl/nbody_step_sequencer.sv
// N-body step sequencer: all-pairs acceleration issue with a latency-matched tag
// line, then a position sweep, repeated for gap steps per software run.
module nbody_step_sequencer #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int ACCL_LATENCY    = 123,
  parameter int ADD_LATENCY     = 20,
  parameter int GAP_WIDTH       = 16
) (
  input logic                   clk,
  input logic                   rst,
  nbody_step_sequencer_if.slave bus
);
  localparam int AW     = BODY_ADDR_WIDTH;
  localparam int WR_LAT = ADD_LATENCY + 1;
  localparam int CNT_W  = $clog2((ACCL_LATENCY > WR_LAT ? ACCL_LATENCY : WR_LAT) + 1);

  typedef enum logic [2:0] {IDLE, ACCEL, ACCEL_DRAIN, POS, POS_DRAIN, DONE} state_t;
  typedef struct packed { logic vld; logic [AW-1:0] i; logic [AW-1:0] j; } tag_t;
  typedef struct packed { logic vld; logic [AW-1:0] addr; } wr_t;

  state_t                    state;
  logic [AW-1:0]             n_last;
  logic [GAP_WIDTH-1:0]      step, step_last;
  logic [CNT_W-1:0]          cnt;
  logic                      rd_vld;
  logic                      abort;
  tag_t [ACCL_LATENCY-1:0]   tag_pipe;
  wr_t  [WR_LAT-1:0]         wr_pipe;

  assign abort = (state inside {ACCEL, ACCEL_DRAIN, POS, POS_DRAIN}) && !bus.go;

  assign bus.acc_valid   = tag_pipe[ACCL_LATENCY-1].vld;
  assign bus.acc_i       = tag_pipe[ACCL_LATENCY-1].i;
  assign bus.acc_j       = tag_pipe[ACCL_LATENCY-1].j;
  assign bus.pos_wr_en   = wr_pipe[WR_LAT-1].vld;
  assign bus.pos_wr_addr = wr_pipe[WR_LAT-1].addr;

  // Tag and write lines run freely; only reset or abort flushes them.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      tag_pipe <= '0;
      wr_pipe  <= '0;
    end else begin
      tag_pipe[0] <= {bus.pair_valid, bus.pair_i, bus.pair_j};
      for (int k = 1; k < ACCL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      wr_pipe[0] <= {rd_vld, bus.pos_rd_addr};
      for (int k = 1; k < WR_LAT; k++) wr_pipe[k] <= wr_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.first_step <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.pair_i     <= '0;
      bus.pair_j     <= '0;
      bus.pos_rd_addr <= '0;
      rd_vld         <= 1'b0;
      n_last         <= '0;
      step           <= '0;
      step_last      <= '0;
      cnt            <= '0;
    end else if (abort) begin
      state          <= IDLE;
      bus.busy       <= 1'b0;
      bus.first_step <= 1'b0;
      bus.pair_valid <= 1'b0;
      bus.pair_i     <= '0;
      bus.pair_j     <= '0;
      bus.pos_rd_addr <= '0;
      rd_vld         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.go && !bus.ack) begin
          // num_bodies==BODIES wraps to 0 here, so n_last still lands on BODIES-1.
          n_last         <= bus.num_bodies[AW-1:0] - AW'(1);
          step_last      <= (bus.gap == '0) ? '0 : bus.gap - GAP_WIDTH'(1);
          step           <= '0;
          bus.first_step <= 1'b1;
          if (bus.num_bodies == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state          <= ACCEL;
            bus.busy       <= 1'b1;
            bus.pair_valid <= 1'b1;
            bus.pair_i     <= '0;
            bus.pair_j     <= '0;
          end
        end
        ACCEL: begin
          if (bus.pair_i == n_last && bus.pair_j == n_last) begin
            state          <= ACCEL_DRAIN;
            bus.pair_valid <= 1'b0;
            cnt            <= '0;
          end else if (bus.pair_j == n_last) begin
            bus.pair_j <= '0;
            bus.pair_i <= bus.pair_i + AW'(1);
          end else begin
            bus.pair_j <= bus.pair_j + AW'(1);
          end
        end
        // Leave exactly one cycle after the last pair emerges from the tag line.
        ACCEL_DRAIN: begin
          if (cnt == CNT_W'(ACCL_LATENCY - 1)) begin
            state           <= POS;
            rd_vld          <= 1'b1;
            bus.pos_rd_addr <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        POS: begin
          if (bus.pos_rd_addr == n_last) begin
            state  <= POS_DRAIN;
            rd_vld <= 1'b0;
            cnt    <= '0;
          end else begin
            bus.pos_rd_addr <= bus.pos_rd_addr + AW'(1);
          end
        end
        POS_DRAIN: begin
          if (cnt == CNT_W'(WR_LAT - 1)) begin
            bus.first_step <= 1'b0;
            if (step == step_last) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              step           <= step + GAP_WIDTH'(1);
              state          <= ACCEL;
              bus.pair_valid <= 1'b1;
              bus.pair_i     <= '0;
              bus.pair_j     <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: if (bus.ack) begin
          state          <= IDLE;
          bus.done       <= 1'b0;
          bus.first_step <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Bench for nbody_step_sequencer: table of runs plus hand sequences for abort,
// mid-run reset and ack-held start; pair/acc/write events checked via queues.
module tb_nbody_step_sequencer;
  localparam int BODIES = 512;
  localparam int AW     = 9;
  localparam int L      = 123;
  localparam int D      = 21;

  typedef struct { int cyc; int i; int j; int fs; } ev_t;
  typedef struct { int n; int g; int ep; int ew; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  int   n_pair = 0, n_acc = 0, n_wr = 0;
  ev_t  pair_q[$], acc_q[$], wr_q[$];
  ev_t  me;

  nbody_step_sequencer_if #(.BODIES(BODIES), .GAP_WIDTH(16)) bus ();

  nbody_step_sequencer #(.BODIES(BODIES), .ACCL_LATENCY(L), .ADD_LATENCY(D - 1), .GAP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int c, input int a, input int b, input int f);
    return {7'd0, c[23:0], a[15:0], b[15:0], f[0]};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.busy, bus.done, bus.first_step, bus.pair_valid, bus.pair_i, bus.pair_j,
                bus.acc_valid, bus.acc_i, bus.acc_j, bus.pos_rd_addr, bus.pos_wr_en, bus.pos_wr_addr});
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pair_valid) begin
        n_pair++;
        if (pair_q.size() == 0)
          chk("pair_unexpected", pk(cyc, int'(bus.pair_i), int'(bus.pair_j), int'(bus.first_step)), 64'(0));
        else begin
          me = pair_q.pop_front();
          chk("pair", pk(cyc, int'(bus.pair_i), int'(bus.pair_j), int'(bus.first_step)), pk(me.cyc, me.i, me.j, me.fs));
        end
      end
      if (bus.acc_valid) begin
        n_acc++;
        if (acc_q.size() == 0)
          chk("acc_unexpected", pk(cyc, int'(bus.acc_i), int'(bus.acc_j), 0), 64'(0));
        else begin
          me = acc_q.pop_front();
          chk("acc", pk(cyc, int'(bus.acc_i), int'(bus.acc_j), 0), pk(me.cyc, me.i, me.j, 0));
        end
      end
      if (bus.pos_wr_en) begin
        n_wr++;
        if (wr_q.size() == 0)
          chk("wr_unexpected", pk(cyc, int'(bus.pos_wr_addr), 0, 0), 64'(0));
        else begin
          me = wr_q.pop_front();
          chk("wr", pk(cyc, int'(bus.pos_wr_addr), 0, 0), pk(me.cyc, me.i, 0, 0));
        end
      end
    end
  end

  // Expected timeline: step s starts at t+1+s*P, P = N*N + L + N + D.
  task automatic push_run(input int t, input int n, input int gg);
    int per, base;
    per = n * n + L + n + D;
    for (int s = 0; s < gg; s++) begin
      base = t + 1 + s * per;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          pair_q.push_back('{base + i * n + j, i, j, (s == 0) ? 1 : 0});
          acc_q.push_back('{base + i * n + j + L, i, j, 0});
        end
      for (int a = 0; a < n; a++) wr_q.push_back('{base + n * n + L + a + D, a, 0, 0});
    end
  endtask

  task automatic run(input int n, input int g, input int ep, input int ew);
    int t, gg, per, dc, w;
    @(posedge clk); #1;
    bus.num_bodies = (AW + 1)'(n);
    bus.gap = 16'(g);
    bus.go = 1'b1;
    bus.ack = 1'b0;
    t = cyc;
    gg = (g == 0) ? 1 : g;
    per = n * n + L + n + D;
    n_pair = 0; n_acc = 0; n_wr = 0;
    if (n > 0) push_run(t, n, gg);
    dc = (n == 0) ? t + 1 : t + 1 + gg * per;
    @(posedge clk); #1;
    bus.num_bodies = (AW + 1)'(7);
    bus.gap = 16'(9);
    chk("busy_start", 64'(bus.busy), 64'(n != 0));
    w = 0;
    while (!bus.done && w < gg * per + 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_cycle", 64'(cyc), 64'(dc));
    chk("done_busy", 64'({bus.done, bus.busy}), 64'(2'b10));
    chk("pair_count", 64'(n_pair), 64'(ep));
    chk("acc_count", 64'(n_acc), 64'(ep));
    chk("wr_count", 64'(n_wr), 64'(ew));
    chk("queues_drained", 64'(pair_q.size() + acc_q.size() + wr_q.size()), 64'(0));
    pair_q.delete(); acc_q.delete(); wr_q.delete();
    bus.ack = 1'b1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    chk("ack_clear", 64'({bus.done, bus.busy}), 64'(0));
    bus.ack = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int t;
    tbl[0] = '{3, 1, 9, 3};
    tbl[1] = '{2, 3, 12, 6};
    tbl[2] = '{1, 1, 1, 1};
    tbl[3] = '{0, 5, 0, 0};
    tbl[4] = '{4, 0, 16, 4};

    bus.go = 1'b0; bus.ack = 1'b0; bus.num_bodies = '0; bus.gap = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'(0));
    rst = 1'b0;

    foreach (tbl[k]) run(tbl[k].n, tbl[k].g, tbl[k].ep, tbl[k].ew);

    // Drop go after five pairs of an N=4 run.
    @(posedge clk); #1;
    bus.num_bodies = (AW + 1)'(4); bus.gap = 16'(1); bus.go = 1'b1;
    t = cyc;
    n_acc = 0; n_wr = 0;
    for (int k = 0; k < 5; k++) pair_q.push_back('{t + 1 + k, k / 4, k % 4, 1});
    repeat (5) @(posedge clk);
    #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", 64'({bus.busy, bus.pair_valid, bus.acc_valid, bus.pos_wr_en, bus.done}), 64'(0));
    repeat (200) @(posedge clk);
    #1;
    chk("abort_quiet", 64'({16'(n_acc), 16'(n_wr), 16'(pair_q.size()), 16'(bus.done)}), 64'(0));

    // Reset in the middle of the N=5 position sweep.
    @(posedge clk); #1;
    bus.num_bodies = (AW + 1)'(5); bus.gap = 16'(1); bus.go = 1'b1;
    t = cyc;
    push_run(t, 5, 1);
    wr_q.delete();
    repeat (151) @(posedge clk);
    #1;
    chk("pos_addr_mid", 64'({bus.busy, bus.pos_rd_addr}), 64'({1'b1, 9'd2}));
    rst = 1'b1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_outs", outs(), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_wr", 64'({bus.pos_wr_en, 8'(pair_q.size() + acc_q.size())}), 64'(0));
    run(1, 1, 1, 1);

    // go with ack held must not start until ack drops.
    @(posedge clk); #1;
    bus.num_bodies = (AW + 1)'(1); bus.gap = 16'(1); bus.go = 1'b1; bus.ack = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ack_held_idle", 64'({bus.busy, bus.done, bus.pair_valid}), 64'(0));
    run(1, 1, 1, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
